muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers, sitting beside the execute stage and fed from the D/X pipeline registers with post-bypass operands. It runs MULT and DIV iteratively (one bit per cycle) and returns HI/LO for MFHI/MFLO. It requests a pipeline stall whenever a HI/LO-dependent instruction reaches execute while an operation is in flight.

## Interface
- MULT_OP, 6'b000010, aluop code that starts a multiply
- DIV_OP, 6'b000011, aluop code that starts a divide
- MFHI_OP, 6'b000100, aluop code that reads HI
- MFLO_OP, 6'b000101, aluop code that reads LO
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- valid  in  1  D/X holds a real instruction (not a bubble)
- aluop  in  6  aluop_DX
- rA  in  32  operand A after MX/WX bypass (dividend / multiplicand)
- rB  in  32  operand B after MX/WX bypass (divisor / multiplier)
- busy  out  1  stall request to fetch/decode and D/X hold logic
- done  out  1  one-cycle pulse when HI/LO are updated
- hilo_out  out  32  HI for MFHI, LO for MFLO, else 0
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- hit = valid & aluop in {MULT_OP, DIV_OP, MFHI_OP, MFLO_OP}; start = valid & aluop in {MULT_OP, DIV_OP} & state==IDLE.
- IDLE, start: latch operand magnitudes and result signs and op type, clear 64-bit accumulator, count=0, go to CALC.
- CALC, MULT: shift-add, one multiplier bit per cycle. CALC, DIV: restoring shift-subtract, one quotient bit per cycle. count increments; after count==31 go to FIX.
- FIX: apply sign correction, write HI/LO, pulse done, go to IDLE.
- MULT result: {HI,LO} = 64-bit product.
- DIV result: LO = quotient truncated toward zero; HI = remainder, with the dividend's sign.
- Divide by zero: LO=32'hFFFFFFFF, HI=rA as latched. No exception is raised.
- 32'h80000000 / -1: LO=32'h80000000, HI=0 (wrap, no trap).
- busy = hit & (state != IDLE), combinational. Non-HI/LO instructions proceed while the unit computes.
- hilo_out is combinational from aluop. It reads HI/LO registers only; there is no forwarding of an in-flight result.
- A start is ignored while state != IDLE. The instruction is held by busy and accepted on the first IDLE cycle.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, count=0, busy=0, done=0, hilo_out=0 (aluop permitting).
- Accepting edge E0. State is CALC for edges E1..E32 and FIX after E32. At E33, HI/LO are written and state returns to IDLE.
- done is high for the single cycle after E33.
- A dependent instruction in X sees busy for 33 cycles after E0 (fewer if it arrives later). It sees the new HI/LO in its first non-busy cycle.
- Back-to-back MULT/DIV: the second is accepted on the cycle state==IDLE, which is the cycle after E33.
- Reset mid-operation: abort immediately. HI/LO go to 0, busy drops without waiting for a clock, and no done pulse is generated.
- A start with valid=0 or an unrecognised aluop leaves all state unchanged.

## Configuration
- MULDIV_SIGNED_EN defined: MULT/DIV treat rA/rB as two's-complement. Operands are converted to magnitudes at start and the result is negated in FIX.
- MULDIV_SIGNED_EN undefined: operands are treated as unsigned. The FIX stage only writes HI/LO, and sign logic is compiled out. Latency is unchanged (33 cycles).

## Test plan
- Assert reset with no clock edge -> busy=0, done=0, hi=0, lo=0 immediately.
- MULT rA=7, rB=32'hFFFFFFFD (signed) -> busy high 33 cycles on a held MFLO, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done pulses once.
- DIV 100/7 -> lo=14, hi=2. DIV -7/2 (signed) -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV rA=32'h12345678, rB=0 -> lo=32'hFFFFFFFF, hi=32'h12345678. Independent ADDs issued during CALC see busy=0.
- MULT followed 2 cycles later by MFHI -> busy held until the done cycle, then hilo_out equals the new hi.
- Reset asserted at CALC count 10 of a DIV -> state IDLE, hi=lo=0, no done pulse. Without MULDIV_SIGNED_EN: MULT 32'hFFFFFFFF*2 -> hi=1, lo=32'hFFFFFFFE.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Pipeline-side handshake for the multiply/divide unit: D/X operands in,
// stall request, completion pulse and HI/LO read-back out.
interface muldiv_unit_if;
  logic        valid;
  logic [5:0]  aluop;
  logic [31:0] rA;
  logic [31:0] rB;
  logic        busy;
  logic        done;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output valid, aluop, rA, rB,
    input  busy, done, hilo_out, hi, lo
  );

  modport slave (
    input  valid, aluop, rA, rB,
    output busy, done, hilo_out, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV with HI/LO: 1 bit per cycle, 33 cycles from accept to HI/LO write.
// Stalls HI/LO-dependent instructions while busy. MULDIV_SIGNED_EN selects two's-complement operands.
module muldiv_unit (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  pipe_io
);
  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q;
  logic [4:0]  count_q;
  logic        op_div_q;
  logic        div0_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
`ifdef MULDIV_SIGNED_EN
  logic        neg_res_q;
  logic        neg_rem_q;
`endif

  logic        is_muldiv;
  logic        hit;
  logic        start;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    is_muldiv = (pipe_io.aluop == MULT_OP) || (pipe_io.aluop == DIV_OP);
    hit       = pipe_io.valid && (is_muldiv || (pipe_io.aluop == MFHI_OP) ||
                                  (pipe_io.aluop == MFLO_OP));
    start     = pipe_io.valid && is_muldiv && (state_q == IDLE);
  end

`ifdef MULDIV_SIGNED_EN
  always_comb begin
    a_mag = pipe_io.rA[31] ? (32'd0 - pipe_io.rA) : pipe_io.rA;
    b_mag = pipe_io.rB[31] ? (32'd0 - pipe_io.rB) : pipe_io.rB;
  end
`else
  always_comb begin
    a_mag = pipe_io.rA;
    b_mag = pipe_io.rB;
  end
`endif

  // MULT: right-shifting accumulator, multiplier bits consumed from opb_q LSB.
  // DIV: {remainder, quotient} in acc_q, dividend bits fed in from opa_q MSB.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    rem_sh   = {acc_q[63:32], opa_q[31]};
    div_diff = rem_sh - {1'b0, opb_q};
    if (div_diff[32]) begin
      div_next = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic [63:0] prod_fix;
  always_comb begin
    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    if (op_div_q) begin
      fix_hi = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      if (div0_q) begin
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_lo = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      end
    end else begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end
  end
`else
  always_comb begin
    fix_hi = acc_q[63:32];
    fix_lo = (op_div_q && div0_q) ? 32'hFFFF_FFFF : acc_q[31:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      op_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q     <= a_mag;
            opb_q     <= b_mag;
            op_div_q  <= (pipe_io.aluop == DIV_OP);
            div0_q    <= (pipe_io.rB == 32'd0);
            acc_q     <= 64'd0;
            count_q   <= 5'd0;
            state_q   <= CALC;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= pipe_io.rA[31] ^ pipe_io.rB[31];
            neg_rem_q <= pipe_io.rA[31];
`endif
          end
        end
        CALC: begin
          if (op_div_q) begin
            acc_q <= div_next;
            opa_q <= {opa_q[30:0], 1'b0};
          end else begin
            acc_q <= mul_next;
            opb_q <= {1'b0, opb_q[31:1]};
          end
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    pipe_io.busy = hit && (state_q != IDLE);
    pipe_io.done = done_q;
    pipe_io.hi   = hi_q;
    pipe_io.lo   = lo_q;
    if (pipe_io.aluop == MFHI_OP) begin
      pipe_io.hilo_out = hi_q;
    end else if (pipe_io.aluop == MFLO_OP) begin
      pipe_io.hilo_out = lo_q;
    end else begin
      pipe_io.hilo_out = 32'd0;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;
  localparam logic [5:0] ADD_OP  = 6'b100000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .pipe_io(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_res(input logic is_div, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] r;
`ifdef MULDIV_SIGNED_EN
    longint sa, sb, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      r = 64'(sa * sb);
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else begin
      q = sa / sb;
      m = sa % sb;
      r = {m[31:0], q[31:0]};
    end
`else
    if (!is_div) begin
      r = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else begin
      r = {a % b, a / b};
    end
`endif
    return r;
  endfunction

  // Timing model: an accepted op occupies the unit for 33 edges, results land on the last.
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_pend = 0;
  int          m_left = 0;
  logic        m_done = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_pend[63:32];
          m_lo = m_pend[31:0];
          m_done = 1;
        end
      end else if (bus.valid && (bus.aluop == MULT_OP || bus.aluop == DIV_OP)) begin
        m_pend = ref_res(bus.aluop == DIV_OP, bus.rA, bus.rB);
        m_left = 33;
      end
    end
  end

  always @(negedge clk) begin
    logic        hit;
    logic [31:0] exp_out;
    hit = bus.valid && (bus.aluop inside {MULT_OP, DIV_OP, MFHI_OP, MFLO_OP});
    exp_out = (bus.aluop == MFHI_OP) ? m_hi : (bus.aluop == MFLO_OP) ? m_lo : 32'd0;
    chk("busy", 64'(bus.busy), 64'(hit && (m_left != 0)));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("hi", 64'(bus.hi), 64'(m_hi));
    chk("lo", 64'(bus.lo), 64'(m_lo));
    chk("hilo_out", 64'(bus.hilo_out), 64'(exp_out));
  end

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.valid = v; bus.aluop = op; bus.rA = a; bus.rB = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present an instruction and hold it while busy, as the D/X hold logic would.
  task automatic issue(input logic v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bit ok;
    ok = 0;
    drive(v, op, a, b);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    drive(0, ADD_OP, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int bcnt, dcnt, extra;
    bit ok;
    logic [5:0] ops [5];
    ops[0] = MULT_OP; ops[1] = DIV_OP; ops[2] = MFHI_OP; ops[3] = MFLO_OP; ops[4] = ADD_OP;
    drive(0, ADD_OP, 32'd0, 32'd0);

    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    step(2);
    rst = 1'b0;

    // MULT 7 * 0xFFFFFFFD with an MFLO held behind it.
    issue(1, MULT_OP, 32'd7, 32'hFFFF_FFFD);
    drive(1, MFLO_OP, 32'd0, 32'd0);
    bcnt = 0; dcnt = 0; ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
      bcnt++;
      if (bus.done) dcnt++;
    end
    chk("mult_wait_bounded", 64'(ok), 64'd1);
    chk("mult_busy_cycles", 64'(bcnt), 64'd33);
    chk("mult_done_first_free", 64'(bus.done), 64'd1);
    chk("mult_done_early", 64'(dcnt), 64'd0);
    chk("mult_mflo", 64'(bus.hilo_out), 64'hFFFF_FFEB);
`ifdef MULDIV_SIGNED_EN
    chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
`else
    chk("mult_hi", 64'(bus.hi), 64'h0000_0006);
`endif
    @(posedge clk); #1;
    drive(0, ADD_OP, 32'd0, 32'd0);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("mult_done_once", 64'(extra), 64'd0);

    issue(1, DIV_OP, 32'd100, 32'd7);
    step(34);
    chk("div100_lo", 64'(bus.lo), 64'd14);
    chk("div100_hi", 64'(bus.hi), 64'd2);

    issue(1, DIV_OP, 32'hFFFF_FFF9, 32'd2);
    step(34);
`ifdef MULDIV_SIGNED_EN
    chk("divneg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("divneg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
`else
    chk("divneg_lo", 64'(bus.lo), 64'h7FFF_FFFC);
    chk("divneg_hi", 64'(bus.hi), 64'h0000_0001);
`endif

    // Divide by zero with independent ADDs flowing past.
    issue(1, DIV_OP, 32'h1234_5678, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1, ADD_OP, 32'(i), 32'd3);
      @(negedge clk);
      chk("add_not_stalled", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
    end
    drive(0, ADD_OP, 32'd0, 32'd0);
    step(30);
    chk("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(bus.hi), 64'h1234_5678);

    // MULT then MFHI two cycles later.
    issue(1, MULT_OP, 32'h0001_0000, 32'h0003_0000);
    step(1);
    drive(1, MFHI_OP, 32'd0, 32'd0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    chk("mfhi_wait_bounded", 64'(ok), 64'd1);
    chk("mfhi_done_cycle", 64'(bus.done), 64'd1);
    chk("mfhi_value", 64'(bus.hilo_out), 64'd3);
    @(posedge clk); #1;
    drive(0, ADD_OP, 32'd0, 32'd0);

    issue(1, DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
    step(34);
`ifdef MULDIV_SIGNED_EN
    chk("ovf_lo", 64'(bus.lo), 64'h8000_0000);
    chk("ovf_hi", 64'(bus.hi), 64'h0000_0000);
`else
    chk("ovf_lo", 64'(bus.lo), 64'h0000_0000);
    chk("ovf_hi", 64'(bus.hi), 64'h8000_0000);
`endif

    // Reset at CALC count 10 of a DIV.
    issue(1, DIV_OP, 32'd1000, 32'd3);
    drive(1, MFLO_OP, 32'd0, 32'd0);
    step(9);
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_hi", 64'(bus.hi), 64'd0);
    chk("mid_rst_lo", 64'(bus.lo), 64'd0);
    chk("mid_rst_hilo", 64'(bus.hilo_out), 64'd0);
    step(1);
    rst = 1'b0;
    drive(0, ADD_OP, 32'd0, 32'd0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("no_done_after_rst", 64'(extra), 64'd0);
    @(posedge clk); #1;

    issue(1, MULT_OP, 32'hFFFF_FFFF, 32'd2);
    step(34);
`ifdef MULDIV_SIGNED_EN
    chk("mulm1_hi", 64'(bus.hi), 64'hFFFF_FFFF);
`else
    chk("mulm1_hi", 64'(bus.hi), 64'h0000_0001);
`endif
    chk("mulm1_lo", 64'(bus.lo), 64'hFFFF_FFFE);

    for (int n = 0; n < 60; n++) begin
      issue(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 4)], rnd_opnd(), rnd_opnd());
      step($urandom_range(0, 40));
    end
    step(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
